rpsd_arb: RTL

RPSD_ARB -- requirements
Module: rpsd_arb

---
 rtl/rpxx_pkg.sv | 15 +
 rtl/rpsd_rrpri.sv | 25 ++
 rtl/rpsd_arb.sv | 137 +++++++++++++
 3 files changed

// File: rtl/rpxx_pkg.sv
// Shared definitions for the RP drive / SD controller arbitration logic.
package rpxx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BUSY  = 3'd2,
    ST_ACK   = 3'd3,
    ST_DLY   = 3'd4
  } rpsd_state_t;

  localparam logic [23:0] RPSD_TIMEOUT_DEF = 24'd10000000;
  localparam logic [2:0]  RPSD_LAST_RST    = 3'd7;

endpackage

// File: rtl/rpsd_rrpri.sv
// Rotating-priority search: first set request at or above base_i, wrapping mod 8.
module rpsd_rrpri (
  input  logic [7:0] req_i,
  input  logic [2:0] base_i,
  output logic       valid_o,
  output logic [2:0] idx_o
);

  logic [15:0] dbl;
  logic [7:0]  rot;
  logic [2:0]  off;

  // Rotate so that base_i lands on bit 0, then take the lowest set bit.
  always_comb begin
    dbl = {req_i, req_i} >> base_i;
    rot = dbl[7:0];
    off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) off = 3'(i);
    end
    valid_o = |req_i;
    idx_o   = base_i + off;
  end

endmodule

// File: rtl/rpsd_arb.sv
// Round-robin arbiter sharing one SD controller among eight RP drives,
// with a BUSY watchdog and Massbus INIT clear.
module rpsd_arb
  import rpxx_pkg::*;
#(
  parameter logic [23:0] TIMEOUT = RPSD_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [7:0]  rpSDREQ,
  output logic [7:0]  rpSDACK,
  output logic [2:0]  sdSCAN,
  output logic        sdGO,
  input  logic        sdDONE,
  output logic        sdABORT,
  output logic        sdBUSY,
  output logic        sdTMO,
  output rpsd_state_t dbg_state
);

  // Handshake: a drive holds rpSDREQ[n] as a level until it sees a one-cycle
  // rpSDACK[n]; the SD side gets a one-cycle sdGO and answers with a
  // one-cycle sdDONE, or is cut short by a one-cycle sdABORT.

  rpsd_state_t state_q, state_d;
  logic [2:0]  scan_q, scan_d;
  logic [2:0]  last_q, last_d;
  logic [23:0] cnt_q, cnt_d;
  logic        tmo_q, tmo_d;
  logic [7:0]  ack_q, ack_d;
  logic        go_q, go_d;
  logic        abort_q, abort_d;
  logic        busy_q, busy_d;

  logic        grant_valid;
  logic [2:0]  grant_idx;

  rpsd_rrpri u_rrpri (
    .req_i   (rpSDREQ),
    .base_i  (last_q + 3'd1),
    .valid_o (grant_valid),
    .idx_o   (grant_idx)
  );

  always_comb begin
    state_d = state_q;
    scan_d  = scan_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    ack_d   = 8'd0;
    go_d    = 1'b0;
    abort_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          scan_d  = grant_idx;
          state_d = ST_START;
        end
      end
      ST_START: begin
        go_d    = 1'b1;
        cnt_d   = 24'd0;
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        cnt_d = cnt_q + 24'd1;
        // A completion in the final watchdog cycle still counts as success.
        if (sdDONE) begin
          state_d = ST_ACK;
        end else if (cnt_q == TIMEOUT - 24'd1) begin
          abort_d = 1'b1;
          tmo_d   = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        ack_d   = 8'd1 << scan_q;
        last_d  = scan_q;
        state_d = ST_DLY;
      end
      ST_DLY: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (clr) begin
      abort_d = (state_q == ST_START) || (state_q == ST_BUSY);
      state_d = ST_IDLE;
      last_d  = RPSD_LAST_RST;
      cnt_d   = 24'd0;
      tmo_d   = 1'b0;
      ack_d   = 8'd0;
      go_d    = 1'b0;
    end

    busy_d = (state_d == ST_START) || (state_d == ST_BUSY) || (state_d == ST_ACK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      scan_q  <= 3'd0;
      last_q  <= RPSD_LAST_RST;
      cnt_q   <= 24'd0;
      tmo_q   <= 1'b0;
      ack_q   <= 8'd0;
      go_q    <= 1'b0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      scan_q  <= scan_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      ack_q   <= ack_d;
      go_q    <= go_d;
      abort_q <= abort_d;
      busy_q  <= busy_d;
    end
  end

  assign rpSDACK   = ack_q;
  assign sdSCAN    = scan_q;
  assign sdGO      = go_q;
  assign sdABORT   = abort_q;
  assign sdBUSY    = busy_q;
  assign sdTMO     = tmo_q;
  assign dbg_state = state_q;

endmodule
